// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: word data memory behind a valid/ready request port that
// answers with a one-cycle response pulse after LATENCY wait states.
module dmem_wait_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    logic [1:0]  r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_acc, w_commit, w_write, w_err;
    logic [31:0] w_addr, w_wdata;
    logic [IW-1:0] w_idx;

    // With zero latency the commit happens on the accepting edge itself, so the
    // live request fields are used there; otherwise the latched copies.
    always_comb begin
        w_acc       = (r_state == S_IDLE) && req_valid_i;
        w_commit    = (w_acc && LATENCY == 0) || (r_state == S_WAIT && r_cnt == 4'd0);
        w_write     = (r_state == S_IDLE) ? req_write_i : r_write;
        w_addr      = (r_state == S_IDLE) ? req_addr_i  : r_addr;
        w_wdata     = (r_state == S_IDLE) ? req_wdata_i : r_wdata;
        w_err       = (|w_addr[1:0]) || (w_addr[31:2] >= 30'(DEPTH));
        w_idx       = w_addr[IW+1:2];
        w_state_nxt = w_commit ? S_RESP :
                      w_acc    ? S_WAIT :
                      (r_state == S_RESP) ? S_IDLE : r_state;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_write <= req_write_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_rdata <= (w_commit && !w_write && !w_err) ? r_mem[w_idx] : 32'd0;
            r_err   <= w_commit && w_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else if (w_commit && w_write && !w_err) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_RESP);
    assign busy_o      = (r_state != S_IDLE);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: directed checks of the wait-state responder with
// LATENCY=2 (dut) and LATENCY=0 (dut0).
module tb_dmem_wait_responder;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0, req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, busy_o;
    logic [31:0] rsp_rdata_o;
    logic        v0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0;
    logic        rdy0, rv0, er0, bz0;
    logic [31:0] rd0;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] rd;
    logic        er;

    always #5 clk_i = ~clk_i;

    dmem_wait_responder #(.DEPTH(128), .LATENCY(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    dmem_wait_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(v0), .req_ready_o(rdy0),
        .req_write_i(w0), .req_addr_i(a0), .req_wdata_i(d0),
        .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(er0), .busy_o(bz0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one request on dut, scrambles the request fields after acceptance
    // so any use of live inputs shows up, and returns the response.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        int n;
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d;
        step();
        req_valid_i = 1'b0; req_write_i = ~w; req_addr_i = a ^ 32'h4; req_wdata_i = ~d;
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            step();
            n++;
        end
        chk("rsp_timeout", {31'd0, rsp_valid_o}, 32'd1);
        r = rsp_rdata_o;
        e = rsp_err_o;
        step();
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b1;
        step();

        // Store 0x08 with cycle-by-cycle timing
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h08; req_wdata_i = 32'hDEADBEEF;
        step();
        req_valid_i = 1'b0;
        chk("t1_c1_ready", {31'd0, req_ready_o}, 32'd0);
        chk("t1_c1_busy", {31'd0, busy_o}, 32'd1);
        chk("t1_c1_valid", {31'd0, rsp_valid_o}, 32'd0);
        step();
        chk("t1_c2_ready", {31'd0, req_ready_o}, 32'd0);
        chk("t1_c2_valid", {31'd0, rsp_valid_o}, 32'd0);
        step();
        chk("t1_c3_ready", {31'd0, req_ready_o}, 32'd0);
        chk("t1_c3_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("t1_c3_err", {31'd0, rsp_err_o}, 32'd0);
        chk("t1_c3_rdata", rsp_rdata_o, 32'd0);
        step();
        chk("t1_c4_ready", {31'd0, req_ready_o}, 32'd1);
        chk("t1_c4_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("t1_c4_busy", {31'd0, busy_o}, 32'd0);

        txn(1'b0, 32'h08, 32'h0, rd, er);
        chk("t2_rdata", rd, 32'hDEADBEEF);
        chk("t2_err", {31'd0, er}, 32'd0);
        chk("t2_rdata_after", rsp_rdata_o, 32'd0);

        txn(1'b0, 32'h0A, 32'h0, rd, er);
        chk("t3_mis_ld_err", {31'd0, er}, 32'd1);
        chk("t3_mis_ld_rdata", rd, 32'd0);
        chk("t3_err_after", {31'd0, rsp_err_o}, 32'd0);
        txn(1'b1, 32'h200, 32'h5555AAAA, rd, er);
        chk("t3_oor_st_err", {31'd0, er}, 32'd1);
        chk("t3_oor_st_rdata", rd, 32'd0);
        txn(1'b1, 32'h0A, 32'h77777777, rd, er);
        chk("t3_mis_st_err", {31'd0, er}, 32'd1);
        txn(1'b0, 32'h1FC, 32'h0, rd, er);
        chk("t3_ld1fc_rdata", rd, 32'd0);
        chk("t3_ld1fc_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h00, 32'h0, rd, er);
        chk("t3_ld0_rdata", rd, 32'd0);
        txn(1'b0, 32'h08, 32'h0, rd, er);
        chk("t3_ld8_intact", rd, 32'hDEADBEEF);

        // Reset during the first WAIT cycle of a store
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'h1234;
        step();
        req_valid_i = 1'b0;
        rst_i = 1'b0;
        #2;
        chk("t4_rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("t4_rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end
        txn(1'b0, 32'h10, 32'h0, rd, er);
        chk("t4_ld10", rd, 32'd0);
        txn(1'b0, 32'h08, 32'h0, rd, er);
        chk("t4_ld8_cleared", rd, 32'd0);

        // LATENCY=0: one store, then back-to-back loads with valid held
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h04; d0 = 32'hA5A5A5A5;
        step();
        v0 = 1'b0;
        chk("t5_st_valid", {31'd0, rv0}, 32'd1);
        chk("t5_st_err", {31'd0, er0}, 32'd0);
        step();
        chk("t5_idle_busy", {31'd0, bz0}, 32'd0);
        v0 = 1'b1; w0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_rsp_valid", {31'd0, rv0}, 32'd1);
            chk("t5_rsp_busy", {31'd0, bz0}, 32'd1);
            chk("t5_rsp_rdata", rd0, 32'hA5A5A5A5);
            step();
            chk("t5_gap_valid", {31'd0, rv0}, 32'd0);
            chk("t5_gap_busy", {31'd0, bz0}, 32'd0);
            chk("t5_gap_rdata", rd0, 32'd0);
        end
        v0 = 1'b0;

        // Inputs scrambled during WAIT must not affect the latched request
        txn(1'b1, 32'h20, 32'hCAFE0001, rd, er);
        txn(1'b1, 32'h24, 32'h11111111, rd, er);
        chk("t6_st_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h24, 32'h0, rd, er);
        chk("t6_ld24", rd, 32'h11111111);
        txn(1'b0, 32'h20, 32'h0, rd, er);
        chk("t6_ld20", rd, 32'hCAFE0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
